// File: rtl/alu_instr_sequencer.sv
// Replays a small stored program of ALU instructions into the ALU/register-file block.
// Each instruction takes four cycles: fetch operands, write, read back, capture the result.
module alu_instr_sequencer #(
   parameter int AW    = 3,
   parameter int DEPTH = 2**AW,
   parameter int DW    = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            prog_we,
   input  logic [AW-1:0]   prog_addr,
   input  logic [2*DW+4:0] prog_data,
   input  logic [AW:0]     prog_len,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [DW-1:0]   A,
   output logic [DW-1:0]   B,
   output logic [1:0]      opcode,
   output logic [2:0]      write_addr,
   output logic            we,
   output logic [2:0]      read_addr,
   input  logic [DW-1:0]   read_data,
   output logic [DW-1:0]   result,
   output logic [2:0]      result_addr,
   output logic            result_valid
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WRITE, S_READ, S_CAPTURE, S_DONE
   } state_t;

   state_t              r_state, w_next;
   logic [2*DW+4:0]     r_prog [DEPTH];
   logic [AW-1:0]       r_pc;
   logic [AW:0]         r_len;
   logic                r_busy, r_done, r_we, r_result_valid;
   logic [DW-1:0]       r_a, r_b, r_result;
   logic [1:0]          r_opcode;
   logic [2:0]          r_write_addr, r_read_addr, r_result_addr;

   logic [2*DW+4:0]     w_slot;
   logic [AW:0]         w_len_clamp;
   logic                w_last;

   assign w_slot      = r_prog[r_pc];
   assign w_len_clamp = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
   assign w_last      = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = (w_len_clamp == '0) ? S_DONE : S_FETCH;
         S_FETCH:   w_next = S_WRITE;
         S_WRITE:   w_next = S_READ;
         S_READ:    w_next = S_CAPTURE;
         S_CAPTURE: w_next = w_last ? S_DONE : S_FETCH;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Program store is only writable while idle, so a run always sees a frozen program.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_prog[i] <= '0;
      end else if (r_state == S_IDLE && prog_we) begin
         r_prog[prog_addr] <= prog_data;
      end
   end

   // Status strobes are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc           <= '0;
         r_len          <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_we           <= 1'b0;
         r_result_valid <= 1'b0;
         r_a            <= '0;
         r_b            <= '0;
         r_opcode       <= '0;
         r_write_addr   <= '0;
         r_read_addr    <= '0;
         r_result       <= '0;
         r_result_addr  <= '0;
      end else begin
         r_busy         <= (w_next != S_IDLE);
         r_done         <= (w_next == S_DONE);
         r_we           <= (w_next == S_WRITE);
         r_result_valid <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_len <= w_len_clamp;
               r_pc  <= '0;
            end
            S_FETCH: begin
               r_opcode     <= w_slot[2*DW+4:2*DW+3];
               r_write_addr <= w_slot[2*DW+2:2*DW];
               r_a          <= w_slot[2*DW-1:DW];
               r_b          <= w_slot[DW-1:0];
            end
            S_WRITE: r_read_addr <= w_slot[2*DW+2:2*DW];
            S_CAPTURE: begin
               r_result       <= read_data;
               r_result_addr  <= r_read_addr;
               r_result_valid <= 1'b1;
               if (!w_last) r_pc <= r_pc + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign A            = r_a;
   assign B            = r_b;
   assign opcode       = r_opcode;
   assign write_addr   = r_write_addr;
   assign we           = r_we;
   assign read_addr    = r_read_addr;
   assign result       = r_result;
   assign result_addr  = r_result_addr;
   assign result_valid = r_result_valid;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer: a behavioural ALU/register file sits downstream, and a
// scoreboard of expected (addr, result) pairs is checked by an independent monitor.
module tb_alu_instr_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        prog_we = 1'b0;
   logic [2:0]  prog_addr = '0;
   logic [20:0] prog_data = '0;
   logic [3:0]  prog_len = '0;
   logic        start = 1'b0;
   wire         busy, done, we, result_valid;
   wire  [7:0]  A, B, result;
   wire  [1:0]  opcode;
   wire  [2:0]  write_addr, read_addr, result_addr;
   wire  [7:0]  read_data;

   logic [7:0]  rf [8];
   logic [20:0] shadow [8];
   logic [10:0] exp_q [$];
   logic [10:0] mon_e;
   int checks = 0, passes = 0, we_cnt = 0, done_cnt = 0, rv_cnt = 0;

   alu_instr_sequencer dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .prog_len(prog_len), .start(start), .busy(busy), .done(done), .A(A), .B(B),
      .opcode(opcode), .write_addr(write_addr), .we(we), .read_addr(read_addr),
      .read_data(read_data), .result(result), .result_addr(result_addr),
      .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return ~(a & b);
         default: return ~(a | b);
      endcase
   endfunction

   function automatic logic [20:0] mk(input logic [1:0] op, input logic [2:0] d, input logic [7:0] a, input logic [7:0] b);
      return {op, d, a, b};
   endfunction

   // Downstream ALU + register file: synchronous write, asynchronous read.
   initial for (int i = 0; i < 8; i++) begin rf[i] = '0; shadow[i] = '0; end
   always @(posedge clk) if (we) rf[write_addr] <= alu_ref(opcode, A, B);
   assign read_data = rf[read_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (we) we_cnt++;
         if (done) done_cnt++;
         if (result_valid) begin
            rv_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_result: got addr=%0d data=%0h, expected none", result_addr, result);
            end else begin
               mon_e = exp_q.pop_front();
               chk("result", {21'd0, result_addr, result}, {21'd0, mon_e});
            end
         end
      end
   end

   task automatic load(input int a, input logic [20:0] d);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 3'(a); prog_data = d;
      @(posedge clk); #1;
      prog_we = 1'b0;
      shadow[a] = d;
   endtask

   // Model: instruction i commits op(A,B) to dest and is read straight back.
   task automatic run(input int l, input bit disturb);
      int n, cyc;
      logic [20:0] s;
      n = (l > 8) ? 8 : l;
      for (int i = 0; i < n; i++) begin
         s = shadow[i];
         exp_q.push_back({s[18:16], alu_ref(s[20:19], s[15:8], s[7:0])});
      end
      we_cnt = 0; done_cnt = 0; rv_cnt = 0;
      @(negedge clk);
      start = 1'b1; prog_len = 4'(l);
      @(posedge clk); #1;
      start = 1'b0; cyc = 1;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      while (!done && cyc < 100) begin
         if (disturb && cyc == 6) begin
            start = 1'b1; prog_we = 1'b1; prog_addr = 3'd0; prog_data = 21'($urandom);
         end else begin
            start = 1'b0; prog_we = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0; prog_we = 1'b0;
      chk("done_cycle", 32'(cyc), 32'(4*n+1));
      @(posedge clk); #1;
      chk("busy_clear", {31'd0, busy}, 32'd0);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("we_cycles", 32'(we_cnt), 32'(n));
      chk("result_count", 32'(rv_cnt), 32'(n));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int cyc;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ops", {8'd0, A, B, 6'd0, opcode}, 32'd0);
      chk("rst_addrs", {23'd0, write_addr, read_addr, result_addr}, 32'd0);
      @(negedge clk); rst = 1'b1;

      // Directed four-op program
      load(0, mk(2'b00, 3'd1, 8'h95, 8'h0F));
      load(1, mk(2'b01, 3'd2, 8'h6A, 8'h0F));
      load(2, mk(2'b10, 3'd3, 8'h53, 8'h0F));
      load(3, mk(2'b11, 3'd4, 8'hAC, 8'h0F));
      run(4, 1'b0);
      chk("ops_hold_last", {22'd0, opcode, A}, {22'd0, 2'b11, 8'hAC});
      chk("raddr_hold_last", {29'd0, read_addr}, 32'd4);

      run(0, 1'b0);

      // Same destination written twice
      load(0, mk(2'b01, 3'd5, 8'hF0, 8'h0F));
      load(1, mk(2'b00, 3'd5, 8'hF0, 8'h0F));
      run(2, 1'b0);

      // start and prog_we during a run are ignored; rerun proves slot 0 intact
      run(2, 1'b1);
      run(2, 1'b0);

      // Length clamp and randomized programs
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 8; i++) load(i, 21'($urandom));
         run((r == 0) ? 15 : int'($urandom_range(0, 15)), 1'b0);
      end

      // Reset while a write is being issued
      load(0, mk(2'b01, 3'd6, 8'h12, 8'h34));
      load(1, mk(2'b10, 3'd7, 8'h56, 8'h78));
      @(negedge clk); start = 1'b1; prog_len = 4'd2;
      @(posedge clk); #1; start = 1'b0; cyc = 0;
      while (!we && cyc < 20) begin @(posedge clk); #1; cyc++; end
      chk("we_seen", {31'd0, we}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_we", {31'd0, we}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_ops", {8'd0, A, B, 6'd0, opcode}, 32'd0);
      chk("midrst_addrs", {23'd0, write_addr, read_addr, result_addr}, 32'd0);
      chk("midrst_result", {23'd0, result_valid, result}, 32'd0);
      exp_q.delete();
      for (int i = 0; i < 8; i++) shadow[i] = '0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
      run(1, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
